uart_rx: RTL

UART receiver; the downstream consumer of the UART transmitter's serial TX_OUT line.
- Oversamples RX_IN at PRESCALE samples per bit and recovers start, data (LSB first), optional parity and stop bits.
- Presents each clean byte on P_DATA with a one-cycle Data_Valid pulse; reports parity and framing errors.
- Uses the same frame format and parity convention as the transmitter: parity_type 1 = even, 0 = odd.

---
 rtl/uart_rx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with parity and framing checks
// Optional 2-of-3 majority vote per bit when UART_RX_MAJORITY_VOTE_EN is defined.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  busy
);
  localparam int EW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [EW-1:0] VOTE_A = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] VOTE_B = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] DECIDE = EW'(PRESCALE / 2 + 1);
`else
  localparam logic [EW-1:0] DECIDE = EW'(PRESCALE / 2);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic                  rx_meta;
  logic                  rx_s;
  logic                  rx_prev;
  logic [EW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en;
  logic                  par_type;
  logic                  par_bad;
  logic                  bit_val;
  logic                  decide;
  logic                  wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote_a;
  logic vote_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else begin
      if (edge_cnt == VOTE_A) vote_a <= rx_s;
      if (edge_cnt == VOTE_B) vote_b <= rx_s;
    end
  end

  // third sample is the live rx_s at the decision point
  assign bit_val = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign decide = (edge_cnt == DECIDE);
  assign wrap   = (edge_cnt == EDGE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      edge_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      par_en        <= 1'b0;
      par_type      <= 1'b0;
      par_bad       <= 1'b0;
      P_DATA        <= '0;
      Data_Valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      Data_Valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      if (state != IDLE) edge_cnt <= wrap ? '0 : edge_cnt + 1'b1;
      case (state)
        IDLE: begin
          busy     <= 1'b0;
          edge_cnt <= '0;
          if (rx_prev && !rx_s) begin
            state    <= START;
            busy     <= 1'b1;
            par_en   <= parity_enable;
            par_type <= parity_type;
            par_bad  <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (decide && bit_val) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wrap) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (decide) shift_reg[bit_cnt] <= bit_val;
          if (wrap) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= par_en ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          // type 1 expects even total ones, type 0 odd
          if (decide && (bit_val != (^shift_reg ^ ~par_type))) par_bad <= 1'b1;
          if (wrap) state <= STOP;
        end
        STOP: begin
          // leave at the sample point so a back-to-back start edge is not missed
          if (decide) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!bit_val) begin
              framing_error <= 1'b1;
            end else if (par_bad) begin
              parity_error <= 1'b1;
            end else begin
              Data_Valid <= 1'b1;
              P_DATA     <= shift_reg;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
